// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle for WIDTH cycles.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // product exposes the accumulator including the current iteration, so the
  // final value is usable on the same edge that completes the last step
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign product  = acc_next;
  assign done     = busy && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (busy) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle multiply.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow output cleared only by rst.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alusel,
  input  logic [WIDTH-1:0] aluin_a,
  input  logic [WIDTH-1:0] aluin_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             nf,
  output logic             zf,
  output logic             cf,
  output logic             ovf
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             ovf_sticky
`endif
);

  state_t state_q, state_d;

  logic               accept, mul_start, res_load;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH:0]     sum, diff, shl;
  logic [WIDTH-1:0]   alu_y, next_y;
  logic               alu_c, alu_v, next_c, next_v;

  assign in_ready  = (state_q == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alusel == OP_MUL);
  assign res_load  = (accept && (alusel != OP_MUL)) || mul_done;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (aluin_a),
    .b       (aluin_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum   = {1'b0, aluin_a} + {1'b0, aluin_b};
    diff  = {1'b0, aluin_a} - {1'b0, aluin_b};
    // the extra top bit catches the last bit shifted out; over-range shifts give zero
    shl   = {1'b0, aluin_a} << aluin_b;
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alusel)
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (aluin_a[WIDTH-1] == aluin_b[WIDTH-1]) && (sum[WIDTH-1] != aluin_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (aluin_a[WIDTH-1] != aluin_b[WIDTH-1]) && (diff[WIDTH-1] != aluin_a[WIDTH-1]);
      end
      OP_AND: alu_y = aluin_a & aluin_b;
      OP_OR:  alu_y = aluin_a | aluin_b;
      OP_XOR: alu_y = aluin_a ^ aluin_b;
      OP_NOT: alu_y = ~aluin_a;
      OP_SHL: begin
        alu_y = shl[WIDTH-1:0];
        alu_c = shl[WIDTH];
      end
      default: ;
    endcase
  end

  assign next_y = mul_done ? mul_p[WIDTH-1:0] : alu_y;
  assign next_c = mul_done ? (|mul_p[2*WIDTH-1:WIDTH]) : alu_c;
  assign next_v = mul_done ? (|mul_p[2*WIDTH-1:WIDTH]) : alu_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      nf        <= 1'b0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      ovf       <= 1'b0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      y         <= next_y;
      nf        <= next_y[WIDTH-1];
      zf        <= (next_y == '0);
      cf        <= next_c;
      ovf       <= next_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)                    ovf_sticky <= 1'b0;
    else if (res_load && next_v) ovf_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes reference results, monitor pops on output.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   alusel;
  logic [W-1:0] aluin_a, aluin_b, y;
  logic         nf, zf, cf, ovf;
`ifdef ALU_STICKY_OVF_EN
  logic         ovf_sticky;
`endif

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alusel    (alusel),
    .aluin_a   (aluin_a),
    .aluin_b   (aluin_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .nf        (nf),
    .zf        (zf),
    .cf        (cf),
    .ovf       (ovf)
`ifdef ALU_STICKY_OVF_EN
    ,
    .ovf_sticky(ovf_sticky)
`endif
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic         nf;
    logic         zf;
    logic         cf;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int unsigned op, input longint unsigned a, input longint unsigned b);
    longint unsigned m    = longint'(1) << W;
    longint          half = longint'(m) / 2;
    longint          sa   = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    longint          sb   = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    longint          r;
    longint unsigned p;
    exp_t            e;
    e = '0;
    case (op)
      0: begin
        p = a + b; r = sa + sb;
        e.y = W'(p % m); e.cf = (p >= m); e.ovf = (r < -half) || (r >= half);
      end
      1: begin
        r = sa - sb;
        e.y = W'((a + m - b) % m); e.cf = (a < b); e.ovf = (r < -half) || (r >= half);
      end
      2: e.y = W'(a & b);
      3: e.y = W'(a | b);
      4: e.y = W'(a ^ b);
      5: e.y = W'((m - 1) - a);
      6: begin
        if (b == 0) e.y = W'(a);
        else if (b <= W) begin
          e.y  = W'((a << b) % m);
          e.cf = ((a >> (W - b)) & 1) != 0;
        end
      end
      default: begin
        p = a * b;
        e.y = W'(p % m); e.cf = (p >= m); e.ovf = (p >= m);
      end
    endcase
    e.nf = (e.y >= W'(m / 2));
    e.zf = (e.y == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the front of the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual y=%0h required no output at %0t", y, $time);
      end else begin
        chk("scoreboard", 64'({y, nf, zf, cf, ovf}), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd_ready);
    bit accepted = 1'b0;
    alusel   = op;
    aluin_a  = a;
    aluin_b  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(int'(op), longint'(a), longint'(b)));
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_flags_y"}, 64'({y, nf, zf, cf, ovf}), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alusel    = '0;
    aluin_a   = '0;
    aluin_b   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");
`ifdef ALU_STICKY_OVF_EN
    chk("reset_sticky", 64'(ovf_sticky), 64'd0);
`endif
    @(posedge clk);
    #1;

    // ADD overflow, visible the cycle after acceptance
    issue(3'b000, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk("add_latency_valid", 64'(out_valid), 64'd1);
    chk("add_7f_01", 64'({y, nf, zf, cf, ovf}), 64'({8'h80, 4'b1001}));
    @(posedge clk);
    #1;

    issue(3'b001, 8'h03, 8'h05, 1'b0);
    issue(3'b001, 8'h05, 8'h05, 1'b0);
    issue(3'b110, 8'h81, 8'd1, 1'b0);
    issue(3'b110, 8'h81, 8'd8, 1'b0);
    issue(3'b110, 8'h81, 8'd9, 1'b0);
    issue(3'b110, 8'h81, 8'd0, 1'b0);
    issue(3'b101, 8'h5A, 8'hFF, 1'b0);

    // MUL: busy for W cycles, result at acceptance + W + 1
    issue(3'b111, 8'h10, 8'h10, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("mul_in_ready_low", 64'(in_ready), 64'd0);
      chk("mul_no_early_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("mul_latency_valid", 64'(out_valid), 64'd1);
    chk("mul_10_10", 64'({y, nf, zf, cf, ovf}), 64'({8'h00, 4'b0111}));
    @(posedge clk);
    #1;
    issue(3'b111, 8'h0F, 8'h0F, 1'b0);
    issue(3'b111, 8'hFF, 8'hFF, 1'b0);
    wait_idle();

    // Backpressure hold, then release and accept on the same edge
    out_ready = 1'b0;
    issue(3'b000, 8'h01, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_y", 64'({out_valid, y}), 64'({1'b1, 8'h02}));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(3'b010, 8'hF0, 8'h3C, 1'b0);
    @(negedge clk);
    chk("and_after_release", 64'({out_valid, y}), 64'({1'b1, 8'h30}));
    wait_idle();

    // Reset four cycles into a MUL discards it
    issue(3'b111, 8'hAB, 8'hCD, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("mul_abort");
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_mul", 64'(out_valid), 64'd0);

`ifdef ALU_STICKY_OVF_EN
    issue(3'b000, 8'h7F, 8'h01, 1'b0);
    issue(3'b000, 8'h01, 8'h01, 1'b0);
    wait_idle();
    chk("sticky_set", 64'(ovf_sticky), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
`endif

    // Randomised traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, 8'($urandom), (op == 3'b110) ? 8'($urandom_range(0, 10)) : 8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the 4-bit combinational ALU.
- Takes WIDTH-bit operands and a 3-bit opcode through a valid/ready input handshake, and returns a registered result plus N/Z/C/V flags through a valid/ready output handshake.
- Adds a multi-cycle unsigned multiply (shift-add).
- Sits between the register file/operand latch and the writeback stage of the lab datapath.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 4..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  opcode and operands are presented.
in_ready  output  1  block can accept an operation this cycle.
alusel  input  3  opcode.
aluin_a  input  WIDTH  operand A.
aluin_b  input  WIDTH  operand B.
out_valid  output  1  y and flags hold a valid result.
out_ready  input  1  downstream consumes the result.
y  output  WIDTH  result.
nf  output  1  negative flag, equal to y[WIDTH-1].
zf  output  1  zero flag, set when y == 0.
cf  output  1  carry/borrow flag.
ovf  output  1  signed overflow flag.

Behaviour:
- Reset: state=IDLE, out_valid=0, y=0, nf=0, zf=0, cf=0, ovf=0. in_ready=1 in the first cycle after reset.
- An operation is accepted on a clk edge where in_valid && in_ready. Operands and opcode are captured on that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput.
- While out_valid && !out_ready, y and all flags hold stable.
- out_valid clears on an edge where out_ready=1 and no new result completes on that edge.
- Opcodes (result truncated to WIDTH bits):
  - 000 ADD: y=a+b. cf=carry out of the MSB. ovf=(a[msb]==b[msb]) && (y[msb]!=a[msb]).
  - 001 SUB: y=a-b. cf=1 when a<b unsigned (borrow). ovf=(a[msb]!=b[msb]) && (y[msb]!=a[msb]).
  - 010 AND, 011 OR, 100 XOR: bitwise. cf=0, ovf=0.
  - 101 NOT: y=~a; b is ignored. cf=0, ovf=0.
  - 110 SHL: y=a<<b, using the full unsigned b as the shift amount.
    - b==0: cf=0.
    - 1<=b<=WIDTH: cf=a[WIDTH-b].
    - b>WIDTH: y=0, cf=0.
    - ovf=0 in all cases.
  - 111 MUL: unsigned 2*WIDTH-bit product p. y=p[WIDTH-1:0]. cf=ovf=(p[2*WIDTH-1:WIDTH]!=0).
- nf and zf are always derived from the final y of every op.
- Latency:
  - Single-cycle ops: out_valid is high in the cycle after acceptance.
  - MUL: WIDTH iteration cycles in state MUL, then the result registers; out_valid is high WIDTH+1 cycles after acceptance.
- FSM:
  - IDLE -> MUL on accepting opcode 111.
  - MUL -> IDLE when the iteration counter reaches WIDTH-1; the result is written on that transition.
  - In MUL, in_ready=0 and in_valid is ignored.
- rst asserted in any state, including mid-MUL, returns to the reset values on that edge. The partial product is discarded and no result is emitted.
- A MUL completing while a previous result is still unconsumed cannot occur, because acceptance required an empty or draining output.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- Defined:
  - Adds output port ovf_sticky (1 bit), reset to 0.
  - ovf_sticky is set on the edge where any result with ovf=1 is registered.
  - ovf_sticky is cleared only by rst.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD..OP_MUL (3 bits).
  - FSM state encoding ST_IDLE, ST_MUL.
- One sub-module: alu_mul_seq.
  - Shift-add unsigned multiplier.
  - Interface: clk, rst, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Instantiated once by alu_seq.

Test Plan (WIDTH=8):
- Reset then ADD 0x7F+0x01 -> next cycle y=0x80, nf=1, zf=0, cf=0, ovf=1, out_valid=1.
- SUB 0x03-0x05 -> y=0xFE, cf=1, nf=1, ovf=0. SUB 0x05-0x05 -> y=0x00, zf=1, cf=0.
- SHL a=0x81: b=1 gives y=0x02, cf=1; b=8 gives y=0x00, cf=1, zf=1; b=9 gives y=0x00, cf=0.
- MUL 0x10*0x10 -> in_ready=0 for 8 cycles, then y=0x00, cf=1, ovf=1, zf=1 at acceptance+9. MUL 0x0F*0x0F -> y=0xE1, cf=0.
- Backpressure: hold out_ready=0 after ADD 0x01+0x01 -> y=0x02 held stable, in_ready=0. Raise out_ready and present AND 0xF0&0x3C on the same edge -> next cycle y=0x30.
- Assert rst for one cycle 4 cycles into MUL -> out_valid=0, all outputs 0, in_ready=1 the following cycle, and no stale MUL result appears. With ALU_STICKY_OVF_EN: ADD 0x7F+0x01 then ADD 0x01+0x01 -> ovf_sticky stays 1 until rst.
